mult_div_hilo: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It is the parametrised, multi-cycle successor to the single-cycle ALU's multiply and divide paths. It produces full double-width products and both quotient and remainder. It sits beside the ALU in the execute stage and stalls the pipeline through `busy` while an operation runs.

---
 rtl/mult_div_hilo.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mult_div_hilo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_hilo.sv
// -----------------------------------------------------------------------------
// mult_div_hilo
//
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply: shift-add, one multiplier bit per cycle, full 2*WIDTH product.
// Divide:   restoring division, one quotient bit per cycle, quotient in LO,
//           remainder in HI.
// Every mul/div op takes WIDTH+1 cycles from accept to result:
// WIDTH CALC cycles followed by one FIX cycle.
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined     - MULT/DIV are signed; magnitude conversion and FIX negation
//                 are built.
//   not defined - MULT behaves as MULTU, DIV as DIVU; no sign logic.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request strobe, sampled only in IDLE
//   op[2:0]      in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                     100 MTHI, 101 MTLO, 11x no-op
//   in1[W-1:0]   in   multiplicand / dividend / MTHI-MTLO data
//   in2[W-1:0]   in   multiplier / divisor
//   busy         out  high while in CALC or FIX
//   done         out  one-cycle pulse after HI/LO are written by a mul/div
//   div_by_zero  out  pulses with done when a divide had in2 == 0
//   hi[W-1:0]    out  HI register (upper product half / remainder)
//   lo[W-1:0]    out  LO register (lower product half / quotient)
// -----------------------------------------------------------------------------
module mult_div_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier/low product}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [DW-1:0]   acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             dvz_q, dvz_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic             dvz_out_q, dvz_out_d;

    logic [WIDTH-1:0] mag1_s, mag2_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] res_hi_s, res_lo_s;

`ifdef MULDIV_SIGNED_EN
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;
    logic signed_op_s, neg1_s, neg2_s;

    assign signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    assign neg1_s      = signed_op_s & in1[WIDTH-1];
    assign neg2_s      = signed_op_s & in2[WIDTH-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign mag1_s      = neg1_s ? (~in1 + WIDTH'(1)) : in1;
    assign mag2_s      = neg2_s ? (~in2 + WIDTH'(1)) : in2;
`else
    assign mag1_s      = in1;
    assign mag2_s      = in2;
`endif

    // Shift-add step: add multiplicand to upper half when the current
    // multiplier bit (acc_q[0]) is set; the carry lands in bit WIDTH.
    assign mul_sum_s   = {1'b0, acc_q[DW-1:WIDTH]}
                       + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});

    // Restoring step. When the trial subtraction succeeds the true
    // difference is below the divisor, so WIDTH bits hold it exactly.
    assign div_shift_s = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_q;
    assign div_rem_s   = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];

    // Final HI/LO values produced in FIX: sign fix-up and divide-by-zero.
    always_comb begin
        res_hi_s = acc_q[DW-1:WIDTH];
        res_lo_s = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            if (dvz_q) begin
                res_hi_s = dividend_q;
                res_lo_s = {WIDTH{1'b1}};
            end else begin
`ifdef MULDIV_SIGNED_EN
                if (neg_res_q) begin
                    res_lo_s = ~acc_q[WIDTH-1:0] + WIDTH'(1);
                end else begin
                    res_lo_s = acc_q[WIDTH-1:0];
                end
                // Remainder follows the sign of the dividend.
                if (neg_rem_q) begin
                    res_hi_s = ~acc_q[DW-1:WIDTH] + WIDTH'(1);
                end else begin
                    res_hi_s = acc_q[DW-1:WIDTH];
                end
`else
                res_hi_s = acc_q[DW-1:WIDTH];
                res_lo_s = acc_q[WIDTH-1:0];
`endif
            end
        end else begin
`ifdef MULDIV_SIGNED_EN
            if (neg_res_q) begin
                {res_hi_s, res_lo_s} = ~acc_q + DW'(1);
            end else begin
                {res_hi_s, res_lo_s} = acc_q;
            end
`else
            {res_hi_s, res_lo_s} = acc_q;
`endif
        end
    end

    // Next-state and datapath control for IDLE/CALC/FIX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        dividend_d = dividend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        dvz_d      = dvz_q;
        done_d     = 1'b0;
        dvz_out_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d    = S_CALC;
                            cnt_d      = CW'(WIDTH - 1);
                            acc_d      = {{WIDTH{1'b0}}, mag2_s};
                            opnd_d     = mag1_s;
                            dividend_d = in1;
                            is_div_d   = 1'b0;
                            dvz_d      = 1'b0;
`ifdef MULDIV_SIGNED_EN
                            neg_res_d  = neg1_s ^ neg2_s;
                            neg_rem_d  = 1'b0;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d    = S_CALC;
                            cnt_d      = CW'(WIDTH - 1);
                            acc_d      = {{WIDTH{1'b0}}, mag1_s};
                            opnd_d     = mag2_s;
                            dividend_d = in1;
                            is_div_d   = 1'b1;
                            dvz_d      = (in2 == {WIDTH{1'b0}});
`ifdef MULDIV_SIGNED_EN
                            neg_res_d  = neg1_s ^ neg2_s;
                            neg_rem_d  = neg1_s;
`endif
                        end
                        OP_MTHI: hi_d = in1;
                        OP_MTLO: lo_d = in1;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d   = S_IDLE;
                hi_d      = res_hi_s;
                lo_d      = res_lo_s;
                done_d    = 1'b1;
                dvz_out_d = dvz_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            acc_q      <= {DW{1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            dividend_q <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            dvz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dvz_out_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            dividend_q <= dividend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            dvz_q      <= dvz_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            dvz_out_q  <= dvz_out_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dvz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_hilo.sv
// -----------------------------------------------------------------------------
// tb_mult_div_hilo
//
// Directed bench for mult_div_hilo at WIDTH=32. Expected HI/LO/div_by_zero
// values are pushed to a scoreboard queue when an operation is launched and
// popped when done is observed. Expected constants follow MULDIV_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_mult_div_hilo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dvz;
    } exp_t;

    exp_t sb_q[$];

`ifdef MULDIV_SIGNED_EN
    localparam logic [31:0] MULT_HI = 32'hFFFFFFFF;
    localparam logic [31:0] DIV_LO  = 32'hFFFFFFFD;
    localparam logic [31:0] DIV_HI  = 32'hFFFFFFFF;
    localparam logic [31:0] OVF_LO  = 32'h80000000;
    localparam logic [31:0] OVF_HI  = 32'h00000000;
`else
    localparam logic [31:0] MULT_HI = 32'h00000004;
    localparam logic [31:0] DIV_LO  = 32'h7FFFFFFC;
    localparam logic [31:0] DIV_HI  = 32'h00000001;
    localparam logic [31:0] OVF_LO  = 32'h00000000;
    localparam logic [31:0] OVF_HI  = 32'h80000000;
`endif

    always #5 clk = ~clk;

    mult_div_hilo #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model returning {div_by_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] x, y, sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sb, sq, sr;
        bit                 sgn;
`ifdef MULDIV_SIGNED_EN
        sgn = (o == 3'b000) || (o == 3'b010);
`else
        sgn = 1'b0;
`endif
        sa = a;
        sb = b;
        if (o[1] == 1'b0) begin
            if (sgn) begin
                x  = $signed({{32{a[31]}}, a});
                y  = $signed({{32{b[31]}}, b});
                sp = x * y;
                return {1'b0, sp};
            end
            up = {32'h0, a} * {32'h0, b};
            return {1'b0, up};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        if (sgn) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
            sq = sa / sb;
            sr = sa % sb;
            return {1'b0, sr, sq};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Launch a mul/div op, follow it to done and compare against the scoreboard.
    // Returns in the done cycle so the next call exercises back-to-back issue.
    // inject_at > 0 pulses an MTLO 0x55 request that many cycles into CALC.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dvz,
                          input string tag, input int inject_at);
        exp_t         e;
        exp_t         got_e;
        logic [W-1:0] lo_before;
        int           n;
        int           busy_n;
        bit           seen;
        e.hi  = e_hi;
        e.lo  = e_lo;
        e.dvz = e_dvz;
        sb_q.push_back(e);
        lo_before = lo;
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        tick();
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        in1   = $urandom;
        in2   = $urandom;
        check({tag, "/busy_accept"}, 64'(busy), 64'(1));
        check({tag, "/done_low_accept"}, 64'(done), 64'(0));
        check({tag, "/dvz_low_accept"}, 64'(div_by_zero), 64'(0));
        busy_n = busy ? 1 : 0;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 100) begin
            if (inject_at != 0 && n == inject_at) begin
                start = 1'b1;
                op    = 3'b101;
                in1   = 32'h55;
            end
            tick();
            n++;
            if (start) begin
                start = 1'b0;
                check({tag, "/lo_held_mid_calc"}, 64'(lo), 64'(lo_before));
            end
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        check({tag, "/latency"}, 64'(n), 64'(W + 1));
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(W + 1));
        check({tag, "/busy_low_done"}, 64'(busy), 64'(0));
        if (sb_q.size() != 0) begin
            got_e = sb_q.pop_front();
            check({tag, "/hi"}, 64'(hi), 64'(got_e.hi));
            check({tag, "/lo"}, 64'(lo), 64'(got_e.lo));
            check({tag, "/dvz"}, 64'(div_by_zero), 64'(got_e.dvz));
        end else begin
            vectors++;
            miscompares++;
            $error("FAIL %s/scoreboard: observed empty queue expected an entry", tag);
        end
    endtask

    initial begin
        logic [64:0]  m;
        logic [2:0]   ro;
        logic [31:0]  ra, rb;
        bit           any_done;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        in1   = 32'h0;
        in2   = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check("reset/hi", 64'(hi), 64'(0));
        check("reset/lo", 64'(lo), 64'(0));
        check("reset/busy", 64'(busy), 64'(0));
        check("reset/done", 64'(done), 64'(0));
        check("reset/dvz", 64'(div_by_zero), 64'(0));

        // MTHI / MTLO / no-op
        start = 1'b1; op = 3'b100; in1 = 32'h12345678;
        tick();
        start = 1'b0;
        check("mthi/hi", 64'(hi), 64'(32'h12345678));
        check("mthi/done", 64'(done), 64'(0));
        check("mthi/busy", 64'(busy), 64'(0));
        start = 1'b1; op = 3'b101; in1 = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        check("mtlo/lo", 64'(lo), 64'(32'h9ABCDEF0));
        check("mtlo/hi_kept", 64'(hi), 64'(32'h12345678));
        check("mtlo/done", 64'(done), 64'(0));
        start = 1'b1; op = 3'b110; in1 = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        check("nop/hi", 64'(hi), 64'(32'h12345678));
        check("nop/lo", 64'(lo), 64'(32'h9ABCDEF0));
        check("nop/busy", 64'(busy), 64'(0));

        // Directed mul/div, issued back to back
        launch(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_full", 0);
        launch(3'b000, 32'hFFFFFFFD, 32'h00000005, MULT_HI, 32'hFFFFFFF1, 1'b0, "mult_neg", 0);
        launch(3'b010, 32'hFFFFFFF9, 32'h00000002, DIV_HI, DIV_LO, 1'b0, "div_neg", 0);
        launch(3'b010, 32'h80000000, 32'hFFFFFFFF, OVF_HI, OVF_LO, 1'b0, "div_ovf", 0);
        launch(3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, "divu_zero", 0);
        launch(3'b001, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0, "multu_inject", 5);

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 2) ? 32'($urandom_range(1, 255)) : $urandom;
            m  = model(ro, ra, rb);
            launch(ro, ra, rb, m[63:32], m[31:0], m[64], "rand", 0);
        end

        tick();
        check("after_done/done", 64'(done), 64'(0));
        check("after_done/busy", 64'(busy), 64'(0));

        // Reset in the middle of CALC aborts the operation
        start = 1'b1; op = 3'b001; in1 = 32'hFFFFFFFF; in2 = 32'h00000002;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort/busy", 64'(busy), 64'(0));
        check("abort/hi", 64'(hi), 64'(0));
        check("abort/lo", 64'(lo), 64'(0));
        check("abort/done", 64'(done), 64'(0));
        any_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done || busy) any_done = 1'b1;
        end
        check("abort/no_done_later", 64'(any_done), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
